// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------
// loader_pkg : shared types and widths for the imem_loader block
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } loader_state_e;

  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

endpackage

`default_nettype wire

// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------
// imem_loader_if : host byte stream, memory write port and status
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

interface imem_loader_if;
  import loader_pkg::*;

  logic              start_i;
  logic              rx_valid_i;
  logic [BYTE_W-1:0] rx_data_i;
  logic              rx_ready_o;
  logic              we_o;
  logic [WORD_W-1:0] waddr_o;
  logic [WORD_W-1:0] wdata_o;
  logic              busy_o;
  logic              cpu_hold_o;
  logic              done_o;
  logic              err_o;
  logic [WORD_W-1:0] checksum_o;

  modport master (
    output start_i, rx_valid_i, rx_data_i,
    input  rx_ready_o, we_o, waddr_o, wdata_o, busy_o, cpu_hold_o,
           done_o, err_o, checksum_o
  );

  modport slave (
    input  start_i, rx_valid_i, rx_data_i,
    output rx_ready_o, we_o, waddr_o, wdata_o, busy_o, cpu_hold_o,
           done_o, err_o, checksum_o
  );

endinterface

`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
// ---------------------------------------------------------------
// byte_packer : little-endian byte-to-word assembly with word pulse
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module byte_packer
  import loader_pkg::*;
(
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              i_clr,
  input  wire logic              i_en,
  input  wire logic [BYTE_W-1:0] i_byte,
  output logic      [WORD_W-1:0] o_word,
  output logic                   o_word_ready
);

  logic [1:0]        r_idx;
  logic [WORD_W-1:0] r_asm;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_idx <= 2'd0;
      r_asm <= '0;
    end else if (i_en) begin
      r_asm[r_idx*BYTE_W +: BYTE_W] <= i_byte;
      r_idx                         <= r_idx + 2'd1;
    end
  end

  // The completed word merges the in-flight top byte so the caller can register it this edge.
  assign o_word_ready = i_en && (r_idx == 2'(BYTES_PER_WORD - 1));
  assign o_word       = {i_byte, r_asm[WORD_W-BYTE_W-1:0]};

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------
// imem_loader : byte-stream program loader into instruction memory
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned       MEM_SIZE  = 2048,
  parameter logic [WORD_W-1:0] BASE_ADDR = 32'h0000_0000
) (
  input  wire logic  clk_i,
  input  wire logic  rst_i,
  imem_loader_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(MEM_SIZE + 1);

  loader_state_e     r_state;
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_final;
  logic              r_rx_ready;
  logic              r_we;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [WORD_W-1:0] r_waddr;
  logic [WORD_W-1:0] r_wdata;
  logic [WORD_W-1:0] r_checksum;

  logic              w_accept;
  logic              w_start;
  logic              w_word_ready;
  logic [WORD_W-1:0] w_word;
  logic              w_last;

  assign w_accept = bus.rx_valid_i && r_rx_ready;
  assign w_start  = bus.start_i &&
                    ((r_state == IDLE) || (r_state == DONE) || (r_state == ERR));
  assign w_last   = (r_cnt + CNT_W'(1)) == r_len;

  byte_packer u_packer (
    .clk          (clk_i),
    .rst          (rst_i),
    .i_clr        (w_start),
    .i_en         (w_accept),
    .i_byte       (bus.rx_data_i),
    .o_word       (w_word),
    .o_word_ready (w_word_ready)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_cnt      <= '0;
      r_final    <= 1'b0;
      r_rx_ready <= 1'b0;
      r_we       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_waddr    <= BASE_ADDR;
      r_wdata    <= '0;
      r_checksum <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        IDLE, DONE, ERR: begin
          if (bus.start_i) begin
            r_state    <= LEN;
            r_cnt      <= '0;
            r_final    <= 1'b0;
            r_checksum <= '0;
            r_rx_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
          end
        end
        LEN: begin
          if (w_word_ready) begin
            if (w_word == '0) begin
              r_state    <= DONE;
              r_rx_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end else if (w_word > MEM_SIZE) begin
              r_state    <= ERR;
              r_rx_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_err      <= 1'b1;
            end else begin
              r_len   <= w_word[CNT_W-1:0];
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          // Final word: ready drops with the write so nothing is taken past the image.
          if (r_final) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_word_ready) begin
            r_we       <= 1'b1;
            r_waddr    <= BASE_ADDR + (WORD_W'(r_cnt) << 2);
            r_wdata    <= w_word;
            r_checksum <= r_checksum + w_word;
            r_cnt      <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_final    <= 1'b1;
              r_rx_ready <= 1'b0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rx_ready_o = r_rx_ready;
  assign bus.we_o       = r_we;
  assign bus.waddr_o    = r_waddr;
  assign bus.wdata_o    = r_wdata;
  assign bus.busy_o     = r_busy;
  assign bus.cpu_hold_o = r_busy;
  assign bus.done_o     = r_done;
  assign bus.err_o      = r_err;
  assign bus.checksum_o = r_checksum;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------
// tb_imem_loader : randomized self-checking bench for imem_loader
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;

  always #5 clk = ~clk;

  imem_loader_if b0 ();
  imem_loader_if b1 ();

  assign b0.start_i    = start;
  assign b0.rx_valid_i = rx_valid;
  assign b0.rx_data_i  = rx_data;
  assign b1.start_i    = start;
  assign b1.rx_valid_i = rx_valid;
  assign b1.rx_data_i  = rx_data;

  imem_loader #(.MEM_SIZE(2048), .BASE_ADDR(32'h0000_0000)) dut0 (
    .clk_i(clk), .rst_i(rst), .bus(b0)
  );
  imem_loader #(.MEM_SIZE(2048), .BASE_ADDR(32'h0000_0100)) dut1 (
    .clk_i(clk), .rst_i(rst), .bus(b1)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cyc = -1;
  int err_cyc = -1;
  int last_acc_cyc = -1;
  logic prev_done = 1'b0;
  logic prev_err = 1'b0;

  logic [31:0] img [0:2047];
  logic [31:0] wa0[$], wd0[$], wa1[$], wd1[$];
  int          wc0[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every we_o pulse seen by either DUT, plus done/err rise times.
  always @(negedge clk) begin
    if (b0.we_o === 1'b1) begin
      wa0.push_back(b0.waddr_o);
      wd0.push_back(b0.wdata_o);
      wc0.push_back(cyc);
    end
    if (b1.we_o === 1'b1) begin
      wa1.push_back(b1.waddr_o);
      wd1.push_back(b1.wdata_o);
    end
    if (b0.done_o && !prev_done) done_cyc = cyc;
    if (b0.err_o && !prev_err) err_cyc = cyc;
    prev_done = b0.done_o;
    prev_err  = b0.err_o;
  end

  function automatic logic [31:0] model_sum(input int n);
    logic [31:0] s = 32'h0;
    for (int i = 0; i < n; i++) s = s + img[i];
    return s;
  endfunction

  task automatic clear_mon();
    wa0.delete(); wd0.delete(); wc0.delete(); wa1.delete(); wd1.delete();
    done_cyc = -1;
    err_cyc  = -1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic rdy;
    logic ok;
    for (int g = 0; g < gap; g++) begin
      rx_valid = 1'b0;
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      rdy = b0.rx_ready_o;
      @(negedge clk);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    rx_valid     = 1'b0;
    last_acc_cyc = cyc;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL send_byte_timeout: byte %02h not accepted, rx_ready=%b, required 1", b, b0.rx_ready_o);
    end
  endtask

  task automatic run_load(input logic [31:0] n, input int nwords, input int max_gap,
                          input int start_at);
    clear_mon();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++)
      send_byte(n[8*k +: 8], (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 1)));
    for (int i = 0; i < nwords; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (i*4 + k == start_at) start = 1'b1;
        send_byte(img[i][8*k +: 8], (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 1)));
        start = 1'b0;
      end
    end
    for (int t = 0; t < 100 && !(b0.done_o || b0.err_o); t++) @(negedge clk);
    tests++;
    if (!(b0.done_o || b0.err_o)) begin
      fails++;
      $display("FAIL load_end_timeout: done=%b err=%b, required one of them 1", b0.done_o, b0.err_o);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({b0.rx_ready_o, b0.we_o, b0.busy_o, b0.cpu_hold_o, b0.done_o, b0.err_o} !== 6'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b, required 000000",
               {b0.rx_ready_o, b0.we_o, b0.busy_o, b0.cpu_hold_o, b0.done_o, b0.err_o});
    end
    tests++;
    if (b0.waddr_o !== 32'h0 || b1.waddr_o !== 32'h100) begin
      fails++;
      $display("FAIL reset_waddr: got %h/%h, required 00000000/00000100", b0.waddr_o, b1.waddr_o);
    end
    tests++;
    if (b0.wdata_o !== 32'h0 || b0.checksum_o !== 32'h0) begin
      fails++;
      $display("FAIL reset_data: wdata %h checksum %h, required 0/0", b0.wdata_o, b0.checksum_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    img[0] = 32'h0050_0093;
    img[1] = 32'h00A0_0113;
    img[2] = 32'h0020_81B3;
    run_load(3, 3, 0, -1);
    tests++;
    if (wa0.size() != 3) begin
      fails++;
      $display("FAIL nominal_count: got %0d writes, required 3", wa0.size());
    end
    for (int i = 0; i < wa0.size(); i++) begin
      tests++;
      if (wa0[i] !== 32'(4*i) || wd0[i] !== img[i]) begin
        fails++;
        $display("FAIL nominal_write%0d: got %h@%h, required %h@%h", i, wd0[i], wa0[i], img[i], 32'(4*i));
      end
    end
    for (int i = 1; i < wc0.size(); i++) begin
      tests++;
      if (wc0[i] - wc0[i-1] != 4) begin
        fails++;
        $display("FAIL nominal_spacing%0d: got %0d cycles, required 4", i, wc0[i] - wc0[i-1]);
      end
    end
    tests++;
    if (b0.checksum_o !== model_sum(3)) begin
      fails++;
      $display("FAIL nominal_checksum: got %h, required %h", b0.checksum_o, model_sum(3));
    end
    tests++;
    if (wc0.size() == 0 || done_cyc != wc0[wc0.size()-1] + 1 || b0.busy_o !== 1'b0) begin
      fails++;
      $display("FAIL nominal_done_timing: done at %0d busy=%b, required one after last write, busy 0",
               done_cyc, b0.busy_o);
    end
  endtask

  task automatic test_gapped();
    int n;
    for (int pass = 0; pass < 2; pass++) begin
      n = 3;
      if (pass == 1) begin
        n = int'($urandom_range(8, 1));
        for (int i = 0; i < n; i++) img[i] = $urandom;
      end
      run_load(32'(n), n, 5, -1);
      tests++;
      if (wa0.size() != n) begin
        fails++;
        $display("FAIL gapped_count%0d: got %0d writes, required %0d", pass, wa0.size(), n);
      end
      for (int i = 0; i < wa0.size(); i++) begin
        tests++;
        if (wa0[i] !== 32'(4*i) || wd0[i] !== img[i]) begin
          fails++;
          $display("FAIL gapped_write%0d_%0d: got %h@%h, required %h@%h", pass, i, wd0[i], wa0[i], img[i], 32'(4*i));
        end
      end
      tests++;
      if (b0.checksum_o !== model_sum(n) || b0.done_o !== 1'b1) begin
        fails++;
        $display("FAIL gapped_checksum%0d: got %h done=%b, required %h done=1", pass, b0.checksum_o, b0.done_o, model_sum(n));
      end
    end
  endtask

  task automatic test_boundaries();
    int bad;
    logic seen_ready;
    run_load(0, 0, 0, -1);
    tests++;
    if (b0.done_o !== 1'b1 || wa0.size() != 0 || done_cyc != last_acc_cyc) begin
      fails++;
      $display("FAIL n0_done: done=%b writes=%0d done_cyc=%0d, required done=1 writes=0 at %0d",
               b0.done_o, wa0.size(), done_cyc, last_acc_cyc);
    end
    for (int i = 0; i < 2048; i++) img[i] = $urandom;
    run_load(2048, 2048, 0, -1);
    tests++;
    if (wa0.size() != 2048 || wa0[wa0.size()-1] !== 32'h1FFC) begin
      fails++;
      $display("FAIL n2048_last: got %0d writes, last addr %h, required 2048 / 00001ffc",
               wa0.size(), (wa0.size() > 0) ? wa0[wa0.size()-1] : 32'hx);
    end
    bad = 0;
    for (int i = 0; i < wa0.size(); i++)
      if (wa0[i] !== 32'(4*i) || wd0[i] !== img[i]) bad++;
    tests++;
    if (bad != 0 || b0.checksum_o !== model_sum(2048)) begin
      fails++;
      $display("FAIL n2048_image: got %0d bad words checksum %h, required 0 / %h", bad, b0.checksum_o, model_sum(2048));
    end
    run_load(2049, 0, 0, -1);
    seen_ready = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    for (int t = 0; t < 5; t++) begin
      if (b0.rx_ready_o) seen_ready = 1'b1;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    tests++;
    if (b0.err_o !== 1'b1 || b0.done_o !== 1'b0 || err_cyc != last_acc_cyc) begin
      fails++;
      $display("FAIL n2049_err: err=%b done=%b err_cyc=%0d, required err=1 done=0 at %0d",
               b0.err_o, b0.done_o, err_cyc, last_acc_cyc);
    end
    tests++;
    if (seen_ready !== 1'b0 || wa0.size() != 0 || b0.busy_o !== 1'b0) begin
      fails++;
      $display("FAIL n2049_quiet: ready_seen=%b writes=%0d busy=%b, required 0/0/0", seen_ready, wa0.size(), b0.busy_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] n2 = 32'd2;
    clear_mon();
    img[0] = $urandom;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) send_byte(n2[8*k +: 8], 0);
    for (int k = 0; k < 2; k++) send_byte(img[0][8*k +: 8], 0);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({b0.rx_ready_o, b0.we_o, b0.busy_o, b0.cpu_hold_o, b0.done_o, b0.err_o} !== 6'b0 ||
        b0.waddr_o !== 32'h0 || b0.wdata_o !== 32'h0 || b0.checksum_o !== 32'h0) begin
      fails++;
      $display("FAIL midreset_outputs: flags %b waddr %h wdata %h sum %h, required all reset values",
               {b0.rx_ready_o, b0.we_o, b0.busy_o, b0.cpu_hold_o, b0.done_o, b0.err_o},
               b0.waddr_o, b0.wdata_o, b0.checksum_o);
    end
    tests++;
    if (wa0.size() != 0) begin
      fails++;
      $display("FAIL midreset_nowrite: got %0d writes, required 0", wa0.size());
    end
    rst = 1'b0;
    @(negedge clk);
    img[0] = $urandom;
    run_load(1, 1, 0, -1);
    tests++;
    if (wa0.size() != 1 || wa0[0] !== 32'h0 || wd0[0] !== img[0] || b0.checksum_o !== img[0]) begin
      fails++;
      $display("FAIL midreset_reload: got %0d writes first %h@%h sum %h, required 1 write %h@00000000",
               wa0.size(), wd0[0], wa0[0], b0.checksum_o, img[0]);
    end
  endtask

  task automatic test_start_handling();
    for (int i = 0; i < 4; i++) img[i] = $urandom;
    run_load(4, 4, 0, 5);
    tests++;
    if (wa0.size() != 4 || b0.done_o !== 1'b1 || b0.checksum_o !== model_sum(4)) begin
      fails++;
      $display("FAIL start_in_data: got %0d writes done=%b sum %h, required 4 / 1 / %h",
               wa0.size(), b0.done_o, b0.checksum_o, model_sum(4));
    end
    for (int i = 0; i < wa0.size(); i++) begin
      tests++;
      if (wa0[i] !== 32'(4*i) || wd0[i] !== img[i]) begin
        fails++;
        $display("FAIL start_in_data_write%0d: got %h@%h, required %h@%h", i, wd0[i], wa0[i], img[i], 32'(4*i));
      end
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (b0.busy_o !== 1'b1 || b0.rx_ready_o !== 1'b1 || b0.checksum_o !== 32'h0 || b0.done_o !== 1'b0) begin
      fails++;
      $display("FAIL restart_clear: busy=%b ready=%b sum %h done=%b, required 1/1/00000000/0",
               b0.busy_o, b0.rx_ready_o, b0.checksum_o, b0.done_o);
    end
    for (int i = 0; i < 2; i++) img[i] = $urandom;
    run_load(2, 2, 2, -1);
    tests++;
    if (wa0.size() != 2 || b0.checksum_o !== model_sum(2)) begin
      fails++;
      $display("FAIL restart_load: got %0d writes sum %h, required 2 / %h", wa0.size(), b0.checksum_o, model_sum(2));
    end
  endtask

  task automatic test_base_addr();
    for (int i = 0; i < 2; i++) img[i] = $urandom;
    run_load(2, 2, 0, -1);
    tests++;
    if (wa1.size() != 2) begin
      fails++;
      $display("FAIL base_count: got %0d writes, required 2", wa1.size());
    end
    for (int i = 0; i < wa1.size(); i++) begin
      tests++;
      if (wa1[i] !== 32'h100 + 32'(4*i) || wd1[i] !== img[i]) begin
        fails++;
        $display("FAIL base_write%0d: got %h@%h, required %h@%h", i, wd1[i], wa1[i], img[i], 32'h100 + 32'(4*i));
      end
    end
    tests++;
    if (b1.checksum_o !== model_sum(2) || b1.done_o !== 1'b1) begin
      fails++;
      $display("FAIL base_checksum: got %h done=%b, required %h done=1", b1.checksum_o, b1.done_o, model_sum(2));
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_gapped();
    test_boundaries();
    test_reset_mid();
    test_start_handling();
    test_base_addr();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
